// File: rtl/agree_pht_if.sv
// rtl/agree_pht_if.sv - fetch prediction and EX training signals of the agree PHT
// slave is the table side, master is the fetch/EX side driving it.
interface agree_pht_if #(
   parameter int GHR_W = 8
);
   logic [31:0]      i_pc_f;
   logic             i_bias_f;
   logic             i_pred_valid;
   logic             o_pred_taken;
   logic [GHR_W-1:0] o_pred_ghr;
   logic             o_ready;
   logic             i_valid_update;
   logic [31:0]      i_pc_ex;
   logic [GHR_W-1:0] i_ghr_ex;
   logic             i_bias_ex;
   logic             i_actual_taken;
   logic             i_mispredict;

   modport slave (
      input  i_pc_f, i_bias_f, i_pred_valid,
      input  i_valid_update, i_pc_ex, i_ghr_ex, i_bias_ex, i_actual_taken, i_mispredict,
      output o_pred_taken, o_pred_ghr, o_ready
   );

   modport master (
      output i_pc_f, i_bias_f, i_pred_valid,
      output i_valid_update, i_pc_ex, i_ghr_ex, i_bias_ex, i_actual_taken, i_mispredict,
      input  o_pred_taken, o_pred_ghr, o_ready
   );
endinterface

// File: rtl/agree_pht.sv
// rtl/agree_pht.sv - agree predictor PHT with gshare indexing and GHR ownership
// Prediction = bias XNOR agree; counters trained through a 2-stage read-modify-write.
module agree_pht #(
   parameter int         IDX_W    = 8,
   parameter int         GHR_W    = 8,
   parameter logic [1:0] CTR_INIT = 2'b10
) (
   input logic         i_clk,
   input logic         i_rst,
   agree_pht_if.slave  bus
);
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] init_ptr;
   logic [1:0]       ctr [DEPTH];
   logic [GHR_W-1:0] ghr, ghr_nxt;

   logic             upd_v;
   logic             upd_agree;
   logic [IDX_W-1:0] upd_idx;

   logic [IDX_W-1:0] idx_f, idx_ex;
   logic [1:0]       upd_old, upd_new, ctr_f;
   logic             run, pred_taken;
   logic             unused_ok;

   assign run    = (state == S_RUN);
   assign idx_f  = bus.i_pc_f[IDX_W+1:2]  ^ IDX_W'(ghr);
   assign idx_ex = bus.i_pc_ex[IDX_W+1:2] ^ IDX_W'(bus.i_ghr_ex);

   assign unused_ok = ^{bus.i_pc_f[31:IDX_W+2], bus.i_pc_f[1:0],
                        bus.i_pc_ex[31:IDX_W+2], bus.i_pc_ex[1:0]};

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (init_ptr == IDX_W'(DEPTH - 1)) state_nxt = S_RUN;
         S_RUN:   state_nxt = S_RUN;
         default: state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)               init_ptr <= '0;
      else if (state == S_INIT) init_ptr <= init_ptr + 1'b1;
   end

   // Stage 2 of training: saturating read-modify-write of the registered index.
   always_comb begin
      upd_old = ctr[upd_idx];
      upd_new = upd_old;
      if (upd_agree) begin
         if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
      end else begin
         if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
      end
   end

   // A prediction racing the in-flight write sees the post-update value.
   always_comb begin
      ctr_f      = (upd_v && (upd_idx == idx_f)) ? upd_new : ctr[idx_f];
      pred_taken = run & ~(bus.i_bias_f ^ ctr_f[1]);
   end

   assign bus.o_pred_taken = pred_taken;
   assign bus.o_pred_ghr   = ghr;
   assign bus.o_ready      = run;

   always_comb begin
      ghr_nxt = ghr;
      if (run) begin
         if (bus.i_valid_update && bus.i_mispredict)
            ghr_nxt = {bus.i_ghr_ex[GHR_W-2:0], bus.i_actual_taken};
         else if (bus.i_pred_valid)
            ghr_nxt = {ghr[GHR_W-2:0], pred_taken};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) ghr <= '0;
      else       ghr <= ghr_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         upd_v     <= 1'b0;
         upd_idx   <= '0;
         upd_agree <= 1'b0;
      end else begin
         upd_v     <= run & bus.i_valid_update;
         upd_idx   <= idx_ex;
         upd_agree <= (bus.i_actual_taken == bus.i_bias_ex);
      end
   end

   // A pending update in the reset cycle is dropped; the sweep rewrites everything anyway.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (state == S_INIT) ctr[init_ptr] <= CTR_INIT;
         else if (upd_v)      ctr[upd_idx]  <= upd_new;
      end
   end
endmodule
